// File: rtl/fault_pkg.sv
// Shared types and constants for the fault response controller.
package fault_pkg;

    localparam int unsigned CODE_W = 4;
    localparam logic [CODE_W-1:0] NO_FAULT = '0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSuspect = 2'd1,
        StRecover = 2'd2,
        StGuard   = 2'd3
    } fault_state_e;

endpackage

// File: rtl/fault_req_handshake.sv
// Recovery request register with ack handshake and bounded wait.
// done_o / timeout_o are single-cycle pulses on the cycle the request retires.
module fault_req_handshake import fault_pkg::*; #(
    parameter int unsigned CODE_W      = fault_pkg::CODE_W,
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              ack_i,
    output logic              req_o,
    output logic [CODE_W-1:0] code_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam int unsigned TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    logic              req_q;
    logic [CODE_W-1:0] code_q;
    logic [TMR_W-1:0]  timer_q;

    // Ack takes priority over expiry on the final cycle.
    assign done_o    = req_q && ack_i;
    assign timeout_o = req_q && !ack_i && (timer_q == TMR_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q   <= 1'b0;
            code_q  <= '0;
            timer_q <= '0;
        end else if (start_i) begin
            req_q   <= 1'b1;
            code_q  <= code_i;
            timer_q <= '0;
        end else if (done_o || timeout_o) begin
            req_q   <= 1'b0;
            timer_q <= '0;
        end else if (req_q) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign req_o  = req_q;
    assign code_o = code_q;

endmodule

// File: rtl/fault_response_ctrl.sv
// Confirms persistent fault codes, drives a recovery request, then holds a
// guard window; keeps sticky status and a saturating confirmed-fault count.
module fault_response_ctrl import fault_pkg::*; #(
    parameter int unsigned CODE_W      = fault_pkg::CODE_W,
    parameter int unsigned CONFIRM_CNT = 3,
    parameter int unsigned CLEAR_CNT   = 8,
    parameter int unsigned ACK_TIMEOUT = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CODE_W-1:0] judge_result_i,
    input  logic              judge_result_en_i,
    input  logic              clear_i,
    input  logic              recov_ack_i,
    output logic              recov_req_o,
    output logic [CODE_W-1:0] recov_code_o,
    output logic              fault_valid_o,
    output logic [CODE_W-1:0] fault_code_o,
    output logic [CNT_W-1:0]  fault_cnt_o,
    output logic              timeout_o,
    output logic [1:0]        state_o
);

    localparam logic [3:0] HIT_LAST   = 4'(CONFIRM_CNT);
    localparam logic [7:0] CLEAN_LAST = 8'(CLEAR_CNT);

    fault_state_e      state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [3:0]        hit_q, hit_d;
    logic [7:0]        clean_q, clean_d;
    logic              confirm;
    logic              is_fault;
    logic              hs_done, hs_timeout;

    logic              valid_q;
    logic [CODE_W-1:0] fcode_q;
    logic [CNT_W-1:0]  fcnt_q;
    logic              tmo_q;

    assign is_fault = (judge_result_i != CODE_W'(NO_FAULT));

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        hit_d   = hit_q;
        clean_d = clean_q;
        confirm = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (judge_result_en_i && is_fault) begin
                    if (CONFIRM_CNT == 1) begin
                        confirm = 1'b1;
                    end else begin
                        cand_d  = judge_result_i;
                        hit_d   = 4'd1;
                        state_d = StSuspect;
                    end
                end
            end
            StSuspect: begin
                if (judge_result_en_i) begin
                    if (!is_fault) begin
                        state_d = StIdle;
                    end else if (judge_result_i == cand_q) begin
                        if (hit_q + 4'd1 == HIT_LAST) confirm = 1'b1;
                        else hit_d = hit_q + 4'd1;
                    end else begin
                        cand_d = judge_result_i;
                        hit_d  = 4'd1;
                    end
                end
            end
            StRecover: begin
                if (hs_done || hs_timeout) begin
                    state_d = StGuard;
                    clean_d = '0;
                end
            end
            StGuard: begin
                if (judge_result_en_i) begin
                    if (is_fault) begin
                        clean_d = '0;
                    end else if (clean_q + 8'd1 == CLEAN_LAST) begin
                        clean_d = '0;
                        state_d = StIdle;
                    end else begin
                        clean_d = clean_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (confirm) begin
            state_d = StRecover;
            cand_d  = judge_result_i;
            hit_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cand_q  <= '0;
            hit_q   <= '0;
            clean_q <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            hit_q   <= hit_d;
            clean_q <= clean_d;
        end
    end

    // Software status: a same-cycle set beats clear_i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            fcode_q <= '0;
            fcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (confirm) begin
                valid_q <= 1'b1;
                fcode_q <= judge_result_i;
                if (clear_i)      fcnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                else if (!(&fcnt_q)) fcnt_q <= fcnt_q + 1'b1;
            end else if (clear_i) begin
                valid_q <= 1'b0;
                fcnt_q  <= '0;
            end
            if (hs_timeout)   tmo_q <= 1'b1;
            else if (clear_i) tmo_q <= 1'b0;
        end
    end

    fault_req_handshake #(
        .CODE_W      (CODE_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_handshake (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (confirm),
        .code_i    (judge_result_i),
        .ack_i     (recov_ack_i),
        .req_o     (recov_req_o),
        .code_o    (recov_code_o),
        .done_o    (hs_done),
        .timeout_o (hs_timeout)
    );

    assign fault_valid_o = valid_q;
    assign fault_code_o  = fcode_q;
    assign fault_cnt_o   = fcnt_q;
    assign timeout_o     = tmo_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fault_response_ctrl.sv
// Directed and randomized checks of fault_response_ctrl against a run-length model.
module tb_fault_response_ctrl;

    localparam int CONFIRM = 3;
    localparam int CLEAR   = 8;
    localparam int TMO     = 256;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic [3:0]      judge_result_i;
    logic            judge_result_en_i;
    logic            clear_i;
    logic            recov_ack_i;
    logic            recov_req_o;
    logic [3:0]      recov_code_o;
    logic            fault_valid_o;
    logic [3:0]      fault_code_o;
    logic [CNTW-1:0] fault_cnt_o;
    logic            timeout_o;
    logic [1:0]      state_o;

    fault_response_ctrl #(
        .CODE_W      (4),
        .CONFIRM_CNT (CONFIRM),
        .CLEAR_CNT   (CLEAR),
        .ACK_TIMEOUT (TMO),
        .CNT_W       (CNTW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .judge_result_i    (judge_result_i),
        .judge_result_en_i (judge_result_en_i),
        .clear_i           (clear_i),
        .recov_ack_i       (recov_ack_i),
        .recov_req_o       (recov_req_o),
        .recov_code_o      (recov_code_o),
        .fault_valid_o     (fault_valid_o),
        .fault_code_o      (fault_code_o),
        .fault_cnt_o       (fault_cnt_o),
        .timeout_o         (timeout_o),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: tracks the current run of identical nonzero samples,
    // the trailing run of clean samples, and the request by its start cycle.
    int m_cyc, m_run_code, m_run_len, m_zero_run, m_req_start, m_req_code;
    int m_valid, m_fcode, m_cnt, m_to;
    bit m_req, m_guard;

    task automatic model_reset();
        m_run_code = 0; m_run_len = 0; m_zero_run = 0; m_req_start = 0; m_req_code = 0;
        m_valid = 0; m_fcode = 0; m_cnt = 0; m_to = 0; m_req = 0; m_guard = 0;
    endtask

    task automatic model_step(input bit en, input int code, input bit ack, input bit clr);
        bit conf = 0;
        bit tmo  = 0;
        if (m_req) begin
            if (ack) begin
                m_req = 0; m_guard = 1; m_zero_run = 0;
            end else if (m_cyc - m_req_start == TMO - 1) begin
                m_req = 0; tmo = 1; m_guard = 1; m_zero_run = 0;
            end
        end else if (m_guard) begin
            if (en) begin
                m_zero_run = (code == 0) ? m_zero_run + 1 : 0;
                if (m_zero_run == CLEAR) begin
                    m_guard = 0; m_run_len = 0;
                end
            end
        end else if (en) begin
            if (code == 0) m_run_len = 0;
            else begin
                if (m_run_len > 0 && code == m_run_code) m_run_len++;
                else begin
                    m_run_code = code; m_run_len = 1;
                end
                if (m_run_len == CONFIRM) begin
                    conf = 1; m_run_len = 0; m_req = 1;
                    m_req_start = m_cyc + 1; m_req_code = code;
                end
            end
        end
        if (clr) begin
            m_valid = 0; m_cnt = 0; m_to = 0;
        end
        if (conf) begin
            m_valid = 1; m_fcode = code;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (tmo) m_to = 1;
        m_cyc++;
    endtask

    task automatic check_outputs();
        int es;
        es = m_req ? 2 : (m_guard ? 3 : (m_run_len > 0 ? 1 : 0));
        check("state", 32'(state_o), 32'(es));
        check("req", 32'(recov_req_o), 32'(m_req));
        if (m_req) check("req_code", 32'(recov_code_o), 32'(m_req_code));
        check("valid", 32'(fault_valid_o), 32'(m_valid));
        check("fcode", 32'(fault_code_o), 32'(m_fcode));
        check("fcnt", 32'(fault_cnt_o), 32'(m_cnt));
        check("timeout", 32'(timeout_o), 32'(m_to));
    endtask

    task automatic cyc(input bit en, input logic [3:0] code, input bit ack, input bit clr);
        judge_result_en_i = en;
        judge_result_i    = code;
        recov_ack_i       = ack;
        clear_i           = clr;
        @(posedge clk);
        model_step(en, int'(code), ack, clr);
        #1;
        check_outputs();
    endtask

    task automatic guard_out();
        for (int i = 0; i < CLEAR; i++) cyc(1'b1, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(recov_req_o), 0);
        check({tag, "_rcode"}, 32'(recov_code_o), 0);
        check({tag, "_valid"}, 32'(fault_valid_o), 0);
        check({tag, "_fcode"}, 32'(fault_code_o), 0);
        check({tag, "_fcnt"}, 32'(fault_cnt_o), 0);
        check({tag, "_tmo"}, 32'(timeout_o), 0);
        check({tag, "_state"}, 32'(state_o), 0);
    endtask

    initial begin
        int n;
        int ack_pct;
        logic [3:0] code;
        logic [3:0] prev;
        logic [3:0] alphabet [3];

        rstn = 1'b0;
        judge_result_i = '0; judge_result_en_i = 1'b0; clear_i = 1'b0; recov_ack_i = 1'b0;
        m_cyc = 0;
        model_reset();
        #23;
        check_reset_outputs("rst");
        rstn = 1'b1;

        // Three matching samples confirm; ack on the first request cycle.
        cyc(1, 4'h5, 0, 0); cyc(1, 4'h5, 0, 0); cyc(1, 4'h5, 0, 0);
        check("t1_req", 32'(recov_req_o), 1);
        check("t1_rcode", 32'(recov_code_o), 5);
        check("t1_cnt", 32'(fault_cnt_o), 1);
        cyc(0, 4'h0, 1, 0);
        check("t1_guard", 32'(state_o), 3);

        // Guard window restarts on a nonzero sample.
        for (int i = 0; i < 7; i++) cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h2, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 4'h0, 0, 0);
        check("t5_still_guard", 32'(state_o), 3);
        cyc(1, 4'h0, 0, 0);
        check("t5_idle", 32'(state_o), 0);

        // Broken run never confirms.
        cyc(1, 4'h5, 0, 0); cyc(1, 4'h5, 0, 0); cyc(1, 4'h0, 0, 0);
        check("t2_idle", 32'(state_o), 0);
        cyc(1, 4'h5, 0, 0); cyc(1, 4'h5, 0, 0);
        check("t2_suspect", 32'(state_o), 1);
        check("t2_noreq", 32'(recov_req_o), 0);
        cyc(1, 4'h0, 0, 0);

        // Candidate switch: request carries the new code.
        cyc(1, 4'h5, 0, 0); cyc(1, 4'h5, 0, 0);
        cyc(1, 4'h3, 0, 0); cyc(1, 4'h3, 0, 0); cyc(1, 4'h3, 0, 0);
        check("t3_rcode", 32'(recov_code_o), 3);
        cyc(1, 4'h7, 1, 0);
        guard_out();

        // No ack: request held for exactly TMO cycles, then timeout.
        cyc(1, 4'h7, 0, 0); cyc(1, 4'h7, 0, 0); cyc(1, 4'h7, 0, 0);
        n = 0;
        for (int i = 0; i < TMO + 40 && recov_req_o; i++) begin
            n++;
            cyc(1, 4'h7, 0, 0);
        end
        check("t4_req_len", 32'(n), 32'(TMO));
        check("t4_timeout", 32'(timeout_o), 1);
        check("t4_guard", 32'(state_o), 3);
        guard_out();

        // Ack on the final timer cycle beats the timeout.
        cyc(0, 4'h0, 0, 1);
        cyc(1, 4'h9, 0, 0); cyc(1, 4'h9, 0, 0); cyc(1, 4'h9, 0, 0);
        for (int i = 0; i < TMO - 1; i++) cyc(0, 4'h0, 0, 0);
        cyc(0, 4'h0, 1, 0);
        check("late_ack_tmo", 32'(timeout_o), 0);
        check("late_ack_guard", 32'(state_o), 3);
        guard_out();

        // Clear on the same cycle as a confirm with count at 7.
        cyc(0, 4'h0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            cyc(1, 4'h1, 0, 0); cyc(1, 4'h1, 0, 0); cyc(1, 4'h1, 0, 0);
            cyc(0, 4'h0, 1, 0);
            guard_out();
        end
        check("t6_cnt7", 32'(fault_cnt_o), 7);
        cyc(1, 4'h4, 0, 0); cyc(1, 4'h4, 0, 0); cyc(1, 4'h4, 0, 1);
        check("t6_cnt1", 32'(fault_cnt_o), 1);
        check("t6_valid", 32'(fault_valid_o), 1);

        // Async reset mid-handshake.
        cyc(0, 4'h0, 0, 0);
        cyc(0, 4'h0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized episodes.
        alphabet[0] = 4'h5; alphabet[1] = 4'h3; alphabet[2] = 4'h9;
        prev = 4'h0;
        for (int ep = 0; ep < 50; ep++) begin
            case ($urandom_range(0, 3))
                0: ack_pct = 0;
                1: ack_pct = 3;
                2: ack_pct = 40;
                default: ack_pct = 100;
            endcase
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 99) < 25) code = 4'h0;
                else if ($urandom_range(0, 99) < 70 && prev != 4'h0) code = prev;
                else code = alphabet[$urandom_range(0, 2)];
                prev = code;
                cyc($urandom_range(0, 99) < 70, code,
                    $urandom_range(0, 99) < ack_pct, $urandom_range(0, 199) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
